lane_sprite_drawer: RTL and testbench

//  Parametrised lane-sprite renderer: places a BOX_W x BOX_H sprite in one of NUM_LANES lanes at a fixed row,

---
 rtl/lane_sprite_drawer_if.sv | 51 +++++
 rtl/lane_sprite_drawer.sv | 239 +++++++++++++++++++++++
 tb/tb_lane_sprite_drawer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/lane_sprite_drawer_if.sv
// ---------------------------------------------------------------------------
// lane_sprite_drawer_if
//   Bundles the request side (from the game-control FSM) and the pixel side
//   (to the VGA frame-buffer write port) of the lane sprite drawer.
//
//   Handshake: the controller raises req with lane_sel/color_in valid; the
//   drawer samples them only when idle and not busy. A request that is not
//   accepted is simply dropped, never queued. busy is high from the first
//   pixel through the done cycle. done pulses for one cycle after the last
//   pixel. x_out/y_out/color_out are meaningful only while plot is high.
//
//   Signals
//     req        controller -> drawer  draw request
//     lane_sel   controller -> drawer  target lane index
//     color_in   controller -> drawer  sprite colour
//     x_out      drawer -> VGA         pixel x
//     y_out      drawer -> VGA         pixel y
//     color_out  drawer -> VGA         pixel colour
//     plot       drawer -> VGA         pixel write strobe
//     busy       drawer -> controller  request in progress
//     done       drawer -> controller  one-cycle completion pulse
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface lane_sprite_drawer_if #(
  parameter int LW = 2,
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3
);
  logic          req;
  logic [LW-1:0] lane_sel;
  logic [CW-1:0] color_in;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [CW-1:0] color_out;
  logic          plot;
  logic          busy;
  logic          done;

  // Game-control side.
  modport master (
    output req, lane_sel, color_in,
    input  x_out, y_out, color_out, plot, busy, done
  );

  // Drawer side.
  modport slave (
    input  req, lane_sel, color_in,
    output x_out, y_out, color_out, plot, busy, done
  );
endinterface

// File: rtl/lane_sprite_drawer.sv
// ---------------------------------------------------------------------------
// lane_sprite_drawer
//   Renders a BOX_W x BOX_H sprite into one of NUM_LANES lanes at row Y_POS,
//   emitting one pixel per clock (row-major) to the frame-buffer write port.
//   Optional erase of the previously drawn sprite is compiled in when the
//   macro SPRITE_ERASE_EN is defined; without it the drawer only draws and
//   the caller is responsible for clearing the old sprite.
//
//   Ports
//     clock        system clock, rising edge
//     reset        asynchronous, active-low reset
//     bus          lane_sprite_drawer_if.slave (request in, pixels out)
//     dbg_state_o  current FSM state (IDLE=0, ERASE=1, DRAW=2, FIN=3)
//
//   Timing: a request accepted at edge k registers its first pixel at k+1,
//   the last of N=BOX_W*BOX_H at k+N (k+2N with erase) and done one edge
//   later. All pixel-port outputs are registered.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module lane_sprite_drawer #(
  parameter int NUM_LANES  = 4,
  parameter int LANE_X0    = 14,
  parameter int LANE_PITCH = 40,
  parameter int Y_POS      = 99,
  parameter int BOX_W      = 4,
  parameter int BOX_H      = 4,
  parameter int XW         = 8,
  parameter int YW         = 7,
  parameter int CW         = 3,
  parameter int LW         = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  lane_sprite_drawer_if.slave  bus,
  output logic [1:0]           dbg_state_o
);

  localparam int CLW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int RLW = (BOX_H > 1) ? $clog2(BOX_H) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [CLW-1:0] col_q, col_d;
  logic [RLW-1:0] row_q, row_d;
  logic [LW-1:0]  lane_q, lane_d;
  logic [CW-1:0]  color_q, color_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [CW-1:0]  cout_q, cout_d;
  logic           plot_q, plot_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
`ifdef SPRITE_ERASE_EN
  logic [LW-1:0]  prev_lane_q, prev_lane_d;
  logic           prev_valid_q, prev_valid_d;
`endif

  logic           req_ok;
  logic           last_col;
  logic           last_row;
  logic           last_px;
  logic [LW-1:0]  px_lane;
  logic [CW-1:0]  px_color;

  // Left edge of a lane, truncated to the x width.
  function automatic logic [XW-1:0] lane_base_x(input logic [LW-1:0] lane);
    lane_base_x = XW'(LANE_X0 + int'(lane) * LANE_PITCH);
  endfunction

  // busy_q lags the state by one edge (outputs are registered), so it also
  // covers the cycle right after FIN where done is still visible; gating on
  // it keeps a request from being accepted while busy is reported high.
  assign req_ok   = bus.req && !busy_q && (int'(bus.lane_sel) < NUM_LANES);
  assign last_col = (col_q == CLW'(BOX_W - 1));
  assign last_row = (row_q == RLW'(BOX_H - 1));
  assign last_px  = last_col && last_row;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_ok) begin
`ifdef SPRITE_ERASE_EN
          state_d = prev_valid_q ? S_ERASE : S_DRAW;
`else
          state_d = S_DRAW;
`endif
        end
      end
      S_ERASE: begin
        if (last_px) state_d = S_DRAW;
      end
      S_DRAW: begin
        if (last_px) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    lane_d   = lane_q;
    color_d  = color_q;
    x_d      = x_q;
    y_d      = y_q;
    cout_d   = cout_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    busy_d   = (state_q != S_IDLE);
    px_lane  = lane_q;
    px_color = color_q;
`ifdef SPRITE_ERASE_EN
    prev_lane_d  = prev_lane_q;
    prev_valid_d = prev_valid_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_ok) begin
          lane_d  = bus.lane_sel;
          color_d = bus.color_in;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_ERASE, S_DRAW: begin
`ifdef SPRITE_ERASE_EN
        // Erase paints the previous sprite position with colour 0.
        if (state_q == S_ERASE) begin
          px_lane  = prev_lane_q;
          px_color = '0;
        end
`endif
        plot_d = 1'b1;
        x_d    = lane_base_x(px_lane) + XW'(col_q);
        y_d    = YW'(Y_POS) + YW'(row_q);
        cout_d = px_color;
        // Counters wrap to zero after the last pixel, which also leaves them
        // cleared for the DRAW pass that follows an ERASE pass.
        if (last_col) begin
          col_d = '0;
          row_d = last_row ? '0 : row_q + RLW'(1);
        end else begin
          col_d = col_q + CLW'(1);
        end
      end
      S_FIN: begin
        done_d = 1'b1;
`ifdef SPRITE_ERASE_EN
        prev_lane_d  = lane_q;
        prev_valid_d = 1'b1;
`endif
      end
      default: begin
        plot_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q   <= '0;
      row_q   <= '0;
      lane_q  <= '0;
      color_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cout_q  <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      lane_q  <= lane_d;
      color_q <= color_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SPRITE_ERASE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_lane_q  <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      prev_lane_q  <= prev_lane_d;
      prev_valid_q <= prev_valid_d;
    end
  end
`endif

  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
  assign bus.color_out = cout_q;
  assign bus.plot      = plot_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lane_sprite_drawer.sv
// ---------------------------------------------------------------------------
// tb_lane_sprite_drawer
//   Directed plus randomized requests against a pixel-list reference model.
//   Main DUT: 4 lanes with a 3-bit lane index so out-of-range lanes can be
//   requested. Second DUT: 6 lanes, 8x2 sprite, pitch 24.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lane_sprite_drawer;

  localparam int NUM_LANES  = 4;
  localparam int LANE_X0    = 14;
  localparam int LANE_PITCH = 40;
  localparam int Y_POS      = 99;
  localparam int BOX_W      = 4;
  localparam int BOX_H      = 4;
  localparam int XW         = 8;
  localparam int YW         = 7;
  localparam int CW         = 3;
  localparam int LW         = 3;
  localparam int N          = BOX_W * BOX_H;
  localparam int PW         = XW + YW + CW;
`ifdef SPRITE_ERASE_EN
  localparam bit ERASE_ON = 1'b1;
`else
  localparam bit ERASE_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lane_sprite_drawer_if #(.LW(LW), .XW(XW), .YW(YW), .CW(CW)) bus ();
  lane_sprite_drawer_if #(.LW(3), .XW(XW), .YW(YW), .CW(CW)) bus6 ();
  logic [1:0] dbg_state;
  logic [1:0] dbg_state6;

  lane_sprite_drawer #(
    .NUM_LANES(NUM_LANES), .LANE_X0(LANE_X0), .LANE_PITCH(LANE_PITCH), .Y_POS(Y_POS),
    .BOX_W(BOX_W), .BOX_H(BOX_H), .XW(XW), .YW(YW), .CW(CW), .LW(LW)
  ) dut (
    .clock(clk), .reset(rst_n), .bus(bus), .dbg_state_o(dbg_state)
  );

  lane_sprite_drawer #(
    .NUM_LANES(6), .LANE_X0(14), .LANE_PITCH(24), .Y_POS(99),
    .BOX_W(8), .BOX_H(2), .XW(XW), .YW(YW), .CW(CW), .LW(3)
  ) dut6 (
    .clock(clk), .reset(rst_n), .bus(bus6), .dbg_state_o(dbg_state6)
  );

  // ---------------- scoreboard ----------------
  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  logic [PW-1:0] exp_q[$];
  bit model_prev_valid = 1'b0;
  int model_prev_lane  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pixel i of a sprite, straight from the geometry: row-major index i maps
  // to column i%bw and row i/bw.
  function automatic logic [PW-1:0] model_pixel(input int lane, input int i, input int color,
                                                input int x0, input int pitch, input int bw);
    int x;
    int y;
    x = (x0 + lane * pitch + i % bw) % (1 << XW);
    y = (Y_POS + i / bw) % (1 << YW);
    return {XW'(x), YW'(y), CW'(color)};
  endfunction

  task automatic push_sprite(input int lane, input int color);
    for (int i = 0; i < N; i++) exp_q.push_back(model_pixel(lane, i, color, LANE_X0, LANE_PITCH, BOX_W));
  endtask

  // ---------------- driver tasks ----------------
  // Issue one request and check every cycle until one past done. With
  // hold=1, req stays high (lane_sel switched to 0) until the done cycle.
  task automatic run_request(input int lane, input int color, input bit hold);
    int npx;
    if (ERASE_ON && model_prev_valid) push_sprite(model_prev_lane, 0);
    push_sprite(lane, color);
    npx = exp_q.size();
    @(negedge clk);
    bus.req      = 1'b1;
    bus.lane_sel = LW'(lane);
    bus.color_in = CW'(color);
    @(posedge clk); #1;
    if (hold) bus.lane_sel = '0;
    else      bus.req = 1'b0;
    for (int t = 1; t <= npx + 2; t++) begin
      @(posedge clk); #1;
      check("busy", bus.busy, (t <= npx + 1));
      check("done", bus.done, (t == npx + 1));
      check("plot", bus.plot, (t <= npx));
      if (bus.plot === 1'b1 && exp_q.size() > 0)
        check("pixel", {bus.x_out, bus.y_out, bus.color_out}, exp_q.pop_front());
      if (hold && t == npx + 1) bus.req = 1'b0;
    end
    check("pixels_left", exp_q.size(), 0);
    exp_q.delete();
    model_prev_valid = 1'b1;
    model_prev_lane  = lane;
  endtask

  task automatic run_invalid(input int lane);
    @(negedge clk);
    bus.req      = 1'b1;
    bus.lane_sel = LW'(lane);
    bus.color_in = CW'($urandom_range(0, 7));
    @(posedge clk); #1;
    bus.req = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      @(posedge clk); #1;
      check("inv_busy", bus.busy, 0);
      check("inv_plot", bus.plot, 0);
      check("inv_done", bus.done, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lane;
    int color;
    int idx;

    bus.req = 1'b0;  bus.lane_sel = '0;  bus.color_in = '0;
    bus6.req = 1'b0; bus6.lane_sel = '0; bus6.color_in = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_plot",  bus.plot, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_done",  bus.done, 0);
    check("rst_x",     bus.x_out, 0);
    check("rst_y",     bus.y_out, 0);
    check("rst_color", bus.color_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lane 0 white, then lane 2 (erase of lane 0 when enabled), then lane 3
    run_request(0, 7, 1'b0);
    run_request(2, 2, 1'b0);
    run_request(3, 5, 1'b0);

    // Out-of-range lanes, including the first one past the end
    run_invalid(5);
    run_invalid(4);
    run_invalid(7);

    // req held during a scan is ignored; a fresh request works afterwards
    run_request(1, 4, 1'b1);
    run_request(0, 6, 1'b0);

    // Reset in the middle of a scan: after the 5th pixel
    if (ERASE_ON && model_prev_valid) push_sprite(model_prev_lane, 0);
    push_sprite(2, 3);
    @(negedge clk);
    bus.req = 1'b1; bus.lane_sel = LW'(2); bus.color_in = CW'(3);
    @(posedge clk); #1;
    bus.req = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      @(posedge clk); #1;
      check("abort_plot", bus.plot, 1);
      if (exp_q.size() > 0) check("abort_pixel", {bus.x_out, bus.y_out, bus.color_out}, exp_q.pop_front());
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_plot_rst",  bus.plot, 0);
    check("abort_busy_rst",  bus.busy, 0);
    check("abort_done_rst",  bus.done, 0);
    check("abort_x_rst",     bus.x_out, 0);
    exp_q.delete();
    model_prev_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      check("post_rst_done", bus.done, 0);
      check("post_rst_plot", bus.plot, 0);
    end
    run_request(1, 1, 1'b0);

    // Randomized mix of valid and invalid lanes
    repeat (12) begin
      lane  = $urandom_range(0, 7);
      color = $urandom_range(0, 7);
      if (lane < NUM_LANES) run_request(lane, color, 1'b0);
      else                  run_invalid(lane);
    end

    // Wide sprite build: lane 5 of 6, 8x2, pitch 24
    @(negedge clk);
    bus6.req = 1'b1; bus6.lane_sel = 3'd5; bus6.color_in = 3'd5;
    @(posedge clk); #1;
    bus6.req = 1'b0;
    idx = 0;
    for (int t = 1; t <= 18; t++) begin
      @(posedge clk); #1;
      check("w_plot", bus6.plot, (t <= 16));
      check("w_done", bus6.done, (t == 17));
      if (bus6.plot === 1'b1) begin
        check("w_pixel", {bus6.x_out, bus6.y_out, bus6.color_out}, model_pixel(5, idx, 5, 14, 24, 8));
        idx++;
      end
    end
    check("w_count", idx, 16);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
